// File: rtl/pam4_ref_ctrl.sv
// pam4_ref_ctrl: 4-PAM slicer reference acquisition/tracking with registered
// decision error and lock detection.
module pam4_ref_ctrl #(
    parameter int ACQ_LOG2 = 4,
    parameter int MU_SHIFT = 4,
    parameter logic signed [17:0] INIT_REF = 18'sd16384,
    parameter logic signed [17:0] REF_MIN = 18'sd64,
    parameter int LOCK_MAX = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sym_en,
    input  logic signed [17:0] dec_var,
    input  logic signed [17:0] out_map_out,
    input  logic               freeze,
    input  logic               restart,
    output logic signed [17:0] ref_level,
    output logic signed [17:0] err,
    output logic               err_valid,
    output logic               acq_done,
    output logic               locked
);
    localparam int AW = 18 + ACQ_LOG2;
    localparam int CW = ACQ_LOG2 + 1;
    localparam int LW = $clog2(LOCK_MAX + 1);
    localparam logic signed [17:0] SMAX = 18'sh1FFFF;
    localparam logic signed [17:0] SMIN = 18'sh20000;
    localparam logic signed [19:0] REF_MIN_X = 20'(REF_MIN);

    typedef enum logic [1:0] {IDLE, ACQ, TRACK, HOLD} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LW-1:0]     lock_q, lock_d;
    logic signed [17:0] ref_q, ref_d, err_q, err_d;
    logic              vld_q, vld_d;

    logic [17:0]        mag;
    logic [AW-1:0]      acc_sum, acq_avg;
    logic signed [17:0] acq_ref, trk_ref, err_sat;
    logic signed [18:0] d_trk, step_trk, diff;
    logic signed [19:0] sum_trk;
    logic [17:0]        err_mag, thr;
    logic               good;

    // The most negative input has no positive twin; saturate its magnitude.
    assign mag = (dec_var == SMIN) ? 18'h1FFFF
               : (dec_var[17] ? $unsigned(-dec_var) : $unsigned(dec_var));

    assign acc_sum = acc_q + AW'(mag);
    assign acq_avg = acc_sum >> ACQ_LOG2;
    assign acq_ref = (acq_avg < AW'($unsigned(REF_MIN))) ? REF_MIN : $signed(acq_avg[17:0]);

    assign d_trk    = $signed({1'b0, mag}) - $signed({ref_q[17], ref_q});
    assign step_trk = d_trk >>> MU_SHIFT;
    assign sum_trk  = $signed({ref_q[17], ref_q[17], ref_q}) + $signed({step_trk[18], step_trk});
    assign trk_ref  = (sum_trk > 20'sd131071) ? SMAX
                    : ((sum_trk < REF_MIN_X) ? REF_MIN : $signed(sum_trk[17:0]));

    assign diff    = $signed({dec_var[17], dec_var}) - $signed({out_map_out[17], out_map_out});
    assign err_sat = (diff[18] != diff[17]) ? (diff[18] ? SMIN : SMAX) : $signed(diff[17:0]);
    assign err_mag = err_sat[17] ? $unsigned(-err_sat) : $unsigned(err_sat);
    assign thr     = $unsigned(ref_q >>> 2);
    assign good    = err_mag < thr;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        lock_d  = lock_q;
        ref_d   = ref_q;
        err_d   = err_q;
        vld_d   = 1'b0;
        if (restart) begin
            state_d = ACQ;
            acc_d   = '0;
            cnt_d   = '0;
            lock_d  = '0;
        end else if (state_q == IDLE) begin
            state_d = ACQ;
            ref_d   = INIT_REF;
        end else if (state_q == ACQ && sym_en) begin
            if (cnt_q == CW'((1 << ACQ_LOG2) - 1)) begin
                state_d = TRACK;
                ref_d   = acq_ref;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
            end
        end else if (state_q == TRACK && freeze) begin
            state_d = HOLD;
        end else if (state_q == TRACK && sym_en) begin
            ref_d  = trk_ref;
            err_d  = err_sat;
            vld_d  = 1'b1;
            lock_d = !good ? '0 : ((lock_q == LW'(LOCK_MAX)) ? lock_q : lock_q + 1'b1);
        end else if (state_q == HOLD && !freeze) begin
            state_d = TRACK;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            lock_q  <= '0;
            ref_q   <= INIT_REF;
            err_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
            ref_q   <= ref_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
        end
    end

    assign ref_level = ref_q;
    assign err       = err_q;
    assign err_valid = vld_q;
    assign acq_done  = (state_q == TRACK) || (state_q == HOLD);
    assign locked    = lock_q == LW'(LOCK_MAX);
endmodule

// File: tb/tb_pam4_ref_ctrl.sv
// tb_pam4_ref_ctrl: directed scenarios plus randomized traffic against an
// integer-arithmetic reference model of the reference-level controller.
module tb_pam4_ref_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sym_en = 1'b0;
    logic freeze = 1'b0;
    logic restart = 1'b0;
    logic signed [17:0] dec_var = '0;
    logic signed [17:0] out_map_out = '0;
    logic signed [17:0] ref_level, err;
    logic err_valid, acq_done, locked;

    int n_vec = 0;
    int n_bad = 0;

    int m_ref = 16384;
    int m_err = 0;
    int m_lock = 0;
    int m_n = 0;
    int m_sum = 0;
    bit m_started = 0;
    bit m_acquired = 0;
    bit m_frozen = 0;
    bit m_vld = 0;

    pam4_ref_ctrl dut (
        .clk(clk), .reset(reset), .sym_en(sym_en), .dec_var(dec_var),
        .out_map_out(out_map_out), .freeze(freeze), .restart(restart),
        .ref_level(ref_level), .err(err), .err_valid(err_valid),
        .acq_done(acq_done), .locked(locked)
    );

    always #5 clk = ~clk;

    function automatic int mag_of(input int v);
        return (v == -131072) ? 131071 : ((v < 0) ? -v : v);
    endfunction

    function automatic int clampi(input int v);
        return (v < 64) ? 64 : ((v > 131071) ? 131071 : v);
    endfunction

    function automatic int sat18(input int v);
        return (v > 131071) ? 131071 : ((v < -131072) ? -131072 : v);
    endfunction

    function automatic int floor_div16(input int v);
        return (v >= 0) ? v / 16 : -((-v + 15) / 16);
    endfunction

    function automatic int rnd_val(input int span);
        return int'($urandom_range(0, 2 * span)) - span;
    endfunction

    task automatic model_update(input bit s, input int dv, input int om, input bit f, input bit r);
        int e;
        bit ok;
        m_vld = 0;
        if (r) begin
            m_started = 1; m_acquired = 0; m_frozen = 0; m_n = 0; m_sum = 0; m_lock = 0;
        end else if (!m_started) begin
            m_started = 1;
        end else if (!m_acquired) begin
            if (s) begin
                m_sum += mag_of(dv);
                m_n++;
                if (m_n == 16) begin
                    m_ref = clampi(m_sum / 16);
                    m_acquired = 1;
                end
            end
        end else if (m_frozen) begin
            m_frozen = f;
        end else if (f) begin
            m_frozen = 1;
        end else if (s) begin
            e = sat18(dv - om);
            ok = ((e < 0) ? -e : e) < m_ref / 4;
            m_ref = clampi(m_ref + floor_div16(mag_of(dv) - m_ref));
            m_err = e;
            m_vld = 1;
            m_lock = ok ? ((m_lock < 15) ? m_lock + 1 : 15) : 0;
        end
    endtask

    task automatic step(input bit s, input int dv, input int om, input bit f, input bit r);
        sym_en = s;
        dec_var = 18'(dv);
        out_map_out = 18'(om);
        freeze = f;
        restart = r;
        @(posedge clk);
        model_update(s, dv, om, f, r);
        #1;
        sym_en = 1'b0;
        restart = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sym_en = 1'b0;
        restart = 1'b0;
        freeze = 1'b0;
        @(posedge clk);
        m_ref = 16384; m_err = 0; m_lock = 0; m_n = 0; m_sum = 0;
        m_started = 0; m_acquired = 0; m_frozen = 0; m_vld = 0;
        #1;
        reset = 1'b0;
    endtask

    task automatic acquire_2000();
        for (int i = 0; i < 16; i++)
            step(1, (($urandom_range(0, 1) != 0) ? -1 : 1) * ((i % 2 != 0) ? 3000 : 1000), 0, 0, 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) step(1, rnd_val(5000), 0, 0, 0);
        do_reset();
        n_vec += 5;
        if (ref_level !== 18'sd16384) begin n_bad++; $display("FAIL reset_ref: got %0d want 16384", ref_level); end
        if (err !== 18'sd0) begin n_bad++; $display("FAIL reset_err: got %0d want 0", err); end
        if (err_valid !== 1'b0) begin n_bad++; $display("FAIL reset_err_valid: got %b want 0", err_valid); end
        if (acq_done !== 1'b0) begin n_bad++; $display("FAIL reset_acq_done: got %b want 0", acq_done); end
        if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b want 0", locked); end
    endtask

    task automatic test_acquisition();
        step(1, 777, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step(1, (($urandom_range(0, 1) != 0) ? -1 : 1) * ((i % 2 != 0) ? 3000 : 1000), 0, 0, 0);
            if (i == 14) begin
                n_vec++;
                if (acq_done !== 1'b0) begin n_bad++; $display("FAIL acq_early_done: got %b want 0", acq_done); end
            end
        end
        n_vec += 2;
        if (ref_level !== 18'sd2000) begin n_bad++; $display("FAIL acq_ref: got %0d want 2000", ref_level); end
        if (acq_done !== 1'b1) begin n_bad++; $display("FAIL acq_done: got %b want 1", acq_done); end
    endtask

    task automatic test_track();
        step(1, 3600, 3000, 0, 0);
        n_vec += 3;
        if (ref_level !== 18'sd2100) begin n_bad++; $display("FAIL track_up: got %0d want 2100", ref_level); end
        if (err !== 18'sd600) begin n_bad++; $display("FAIL track_err: got %0d want 600", err); end
        if (err_valid !== 1'b1) begin n_bad++; $display("FAIL track_err_valid: got %b want 1", err_valid); end
        step(1, -400, -1000, 0, 0);
        n_vec++;
        if (ref_level !== 18'sd1993) begin n_bad++; $display("FAIL track_down: got %0d want 1993", ref_level); end
    endtask

    task automatic test_lock();
        step(0, 0, 0, 0, 1);
        acquire_2000();
        for (int i = 0; i < 15; i++) begin
            step(1, 3200, 3000, 0, 0);
            n_vec += 2;
            if (err !== 18'sd200) begin n_bad++; $display("FAIL lock_err[%0d]: got %0d want 200", i, err); end
            if (locked !== (i == 14)) begin n_bad++; $display("FAIL lock_ramp[%0d]: got %b want %b", i, locked, i == 14); end
        end
        step(1, 3200, 2300, 0, 0);
        n_vec += 2;
        if (err !== 18'sd900) begin n_bad++; $display("FAIL lock_bad_err: got %0d want 900", err); end
        if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_drop: got %b want 0", locked); end
        step(0, 0, 0, 0, 0);
        n_vec++;
        if (err_valid !== 1'b0) begin n_bad++; $display("FAIL err_valid_pulse: got %b want 0", err_valid); end
    endtask

    task automatic test_saturation();
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(1, -131072, 0, 1, 0);
        n_vec += 2;
        if (ref_level !== 18'sd131071) begin n_bad++; $display("FAIL sat_mag_ref: got %0d want 131071", ref_level); end
        if (acq_done !== 1'b1) begin n_bad++; $display("FAIL sat_freeze_ignored: got %b want 1", acq_done); end
        step(1, 131071, -131072, 0, 0);
        n_vec++;
        if (err !== 18'sd131071) begin n_bad++; $display("FAIL sat_err: got %0d want 131071", err); end
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0);
        n_vec++;
        if (ref_level !== 18'sd64) begin n_bad++; $display("FAIL clamp_min: got %0d want 64", ref_level); end
    endtask

    task automatic test_freeze();
        int r0, e0;
        for (int i = 0; i < 4; i++) step(1, rnd_val(3000), rnd_val(3000), 0, 0);
        r0 = m_ref;
        e0 = m_err;
        for (int i = 0; i < 10; i++) begin
            step(1, rnd_val(60000), rnd_val(60000), 1, 0);
            n_vec += 4;
            if (ref_level !== r0) begin n_bad++; $display("FAIL freeze_ref[%0d]: got %0d want %0d", i, ref_level, r0); end
            if (err !== e0) begin n_bad++; $display("FAIL freeze_err[%0d]: got %0d want %0d", i, err, e0); end
            if (err_valid !== 1'b0) begin n_bad++; $display("FAIL freeze_valid[%0d]: got %b want 0", i, err_valid); end
            if (acq_done !== 1'b1) begin n_bad++; $display("FAIL freeze_acq_done[%0d]: got %b want 1", i, acq_done); end
        end
        step(0, 0, 0, 0, 0);
        step(1, 5000, 4000, 0, 0);
        n_vec += 2;
        if (err_valid !== 1'b1) begin n_bad++; $display("FAIL unfreeze_valid: got %b want 1", err_valid); end
        if (err !== 18'sd1000) begin n_bad++; $display("FAIL unfreeze_err: got %0d want 1000", err); end
    endtask

    task automatic test_restart();
        int r0, sum;
        r0 = m_ref;
        step(1, 50000, 0, 1, 1);
        n_vec += 3;
        if (acq_done !== 1'b0) begin n_bad++; $display("FAIL restart_acq_done: got %b want 0", acq_done); end
        if (err_valid !== 1'b0) begin n_bad++; $display("FAIL restart_drop: got %b want 0", err_valid); end
        if (ref_level !== r0) begin n_bad++; $display("FAIL restart_ref_kept: got %0d want %0d", ref_level, r0); end
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            int v;
            v = rnd_val(20000);
            sum += mag_of(v);
            step(1, v, 0, 0, 0);
            if (i == 14) begin
                n_vec += 2;
                if (acq_done !== 1'b0) begin n_bad++; $display("FAIL restart_window: got %b want 0", acq_done); end
                if (ref_level !== r0) begin n_bad++; $display("FAIL restart_ref_hold: got %0d want %0d", ref_level, r0); end
            end
        end
        n_vec += 2;
        if (acq_done !== 1'b1) begin n_bad++; $display("FAIL restart_reacq: got %b want 1", acq_done); end
        if (ref_level !== clampi(sum / 16)) begin n_bad++; $display("FAIL restart_avg: got %0d want %0d", ref_level, clampi(sum / 16)); end
    endtask

    task automatic test_mid_reset();
        int sum;
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) step(1, rnd_val(9000), 0, 0, 0);
        do_reset();
        n_vec += 3;
        if (ref_level !== 18'sd16384) begin n_bad++; $display("FAIL midrst_ref: got %0d want 16384", ref_level); end
        if (acq_done !== 1'b0) begin n_bad++; $display("FAIL midrst_acq_done: got %b want 0", acq_done); end
        if (err !== 18'sd0) begin n_bad++; $display("FAIL midrst_err: got %0d want 0", err); end
        step(0, 0, 0, 0, 0);
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            int v;
            v = rnd_val(9000);
            sum += mag_of(v);
            step(1, v, 0, 0, 0);
            if (i == 14) begin
                n_vec++;
                if (acq_done !== 1'b0) begin n_bad++; $display("FAIL midrst_window: got %b want 0", acq_done); end
            end
        end
        n_vec += 2;
        if (acq_done !== 1'b1) begin n_bad++; $display("FAIL midrst_done: got %b want 1", acq_done); end
        if (ref_level !== clampi(sum / 16)) begin n_bad++; $display("FAIL midrst_ref_avg: got %0d want %0d", ref_level, clampi(sum / 16)); end
    endtask

    task automatic test_random();
        bit f;
        int dv, om, sel;
        f = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 799) == 0) do_reset();
            if ($urandom_range(0, 31) == 0) f = !f;
            sel = int'($urandom_range(0, 9));
            dv = (sel == 0) ? -131072 : ((sel == 1) ? 131071 : rnd_val(40000));
            om = (sel == 2) ? rnd_val(131072) : sat18(dv + rnd_val(1500));
            if (om > 131071) om = 131071;
            step($urandom_range(0, 3) != 0, dv, om, f, $urandom_range(0, 199) == 0);
            n_vec += 5;
            if (ref_level !== m_ref) begin n_bad++; $display("FAIL rnd_ref[%0d]: got %0d want %0d", c, ref_level, m_ref); end
            if (err !== m_err) begin n_bad++; $display("FAIL rnd_err[%0d]: got %0d want %0d", c, err, m_err); end
            if (err_valid !== m_vld) begin n_bad++; $display("FAIL rnd_err_valid[%0d]: got %b want %b", c, err_valid, m_vld); end
            if (acq_done !== m_acquired) begin n_bad++; $display("FAIL rnd_acq_done[%0d]: got %b want %b", c, acq_done, m_acquired); end
            if (locked !== (m_lock == 15)) begin n_bad++; $display("FAIL rnd_locked[%0d]: got %b want %b", c, locked, m_lock == 15); end
        end
    endtask

    initial begin
        test_reset();
        test_acquisition();
        test_track();
        test_lock();
        test_saturation();
        test_freeze();
        test_restart();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
